pulse_scheduler: RTL and testbench

//   Shares one single-cycle pulse output channel among N_REQ level request inputs.

---
 rtl/pulse_scheduler.sv | 113 +++++++++++
 tb/tb_pulse_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
// Shares one single-cycle pulse channel among N_REQ level requests: rising edges are
// latched as pending events and granted round-robin, with GAP_CYCLES idle cycles after each pulse.
module pulse_scheduler #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 3,
    localparam int ID_W      = $clog2(N_REQ),
    localparam int CNT_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req_in,
    input  logic             enable,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic [ID_W-1:0]  pulse_id,
    output logic [N_REQ-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [ID_W-1:0]    ptr, ptr_next;
    logic [N_REQ-1:0]   req_q;
    logic [N_REQ-1:0]   rise;
    logic [N_REQ-1:0]   grant_mask;
    logic [N_REQ-1:0]   lost;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               grant;
    int                 idx;

    // Round-robin search: first pending bit at or above ptr, wrapping past N_REQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && pending[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        grant      = (state == IDLE) && enable && found;
        grant_mask = '0;
        if (grant) grant_mask[winner] = 1'b1;
        rise       = req_in & ~req_q;
        lost       = rise & pending & ~grant_mask;
        ptr_next   = ptr;
        if (grant) ptr_next = (int'(winner) == N_REQ - 1) ? '0 : winner + ID_W'(1);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (grant) state_next = FIRE;
            end
            FIRE: begin
                if (GAP_CYCLES > 0) begin
                    state_next = GAP;
                    cnt_next   = CNT_W'(GAP_CYCLES);
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (cnt <= CNT_W'(1)) state_next = IDLE;
                else                  cnt_next   = cnt - CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            req_q     <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            pulse_out <= 1'b0;
            pulse_id  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ptr       <= ptr_next;
            req_q     <= req_in;
            pending   <= (pending & ~grant_mask) | rise;
            if (|lost)        overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            pulse_out <= (state_next == FIRE);
            busy      <= (state_next != IDLE);
            if (grant) pulse_id <= winner;
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler: directed scenarios plus random traffic,
// all compared against a cycle-level reference model built from the behavioural rules.
module tb_pulse_scheduler;

    localparam int N_REQ      = 4;
    localparam int GAP_CYCLES = 3;
    localparam int ID_W       = $clog2(N_REQ);
    localparam int VW         = ID_W + N_REQ + 3;

    logic             CLK     = 1'b0;
    logic             RST     = 1'b1;
    logic [N_REQ-1:0] req_in  = '0;
    logic             enable  = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             pulse_out;
    logic [ID_W-1:0]  pulse_id;
    logic [N_REQ-1:0] pending;
    logic             busy;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    pulse_scheduler #(.N_REQ(N_REQ), .GAP_CYCLES(GAP_CYCLES)) dut (
        .CLK(CLK), .RST(RST), .req_in(req_in), .enable(enable), .clr_ovf(clr_ovf),
        .pulse_out(pulse_out), .pulse_id(pulse_id), .pending(pending),
        .busy(busy), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // Reference model: busy time is a plain countdown of cycles left before a new grant.
    logic [N_REQ-1:0] m_seen = '0, m_pend = '0, m_rise = '0, m_take = '0, m_lost = '0;
    logic             m_ovf = 1'b0, m_pulse = 1'b0;
    int               m_ptr = 0, m_id = 0, m_busy_left = 0, m_win = -1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_seen = '0; m_pend = '0; m_ovf = 1'b0; m_pulse = 1'b0;
            m_ptr = 0; m_id = 0; m_busy_left = 0;
        end else begin
            m_rise = req_in & ~m_seen;
            m_win  = -1;
            if (m_busy_left == 0 && enable && m_pend != '0)
                for (int k = 0; k < N_REQ; k++)
                    if (m_win < 0 && m_pend[(m_ptr + k) % N_REQ]) m_win = (m_ptr + k) % N_REQ;
            m_take = '0;
            if (m_win >= 0) m_take[m_win] = 1'b1;
            m_lost = m_rise & m_pend & ~m_take;
            m_pend = (m_pend & ~m_take) | m_rise;
            if (m_lost != '0) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_seen = req_in;
            if (m_win >= 0) begin
                m_pulse = 1'b1; m_id = m_win; m_ptr = (m_win + 1) % N_REQ;
                m_busy_left = 1 + GAP_CYCLES;
            end else begin
                m_pulse = 1'b0;
                if (m_busy_left > 0) m_busy_left--;
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        return {m_pulse, ID_W'(m_id), m_pend, (m_busy_left != 0), m_ovf};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {pulse_out, pulse_id, pending, busy, overflow};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; req_in = '0; enable = 1'b0; clr_ovf = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_in = N_REQ'($urandom);
            @(negedge CLK);
        end
        #2 RST = 1'b1; req_in = '0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b required %b", obs_vec(), {VW{1'b0}});
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            checks++;
            if (pulse_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_quiet cyc %0d: pulse_out %b required 0", c, pulse_out);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL reset_model cyc %0d: got %b required %b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        int first = -1;
        logic [ID_W-1:0] id_seen = '0;
        do_reset();
        enable = 1'b1;
        req_in = 4'b0100;
        for (int c = 1; c <= 16; c++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL single_model cyc %0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            if (pulse_out) begin
                pulses++;
                if (first < 0) begin first = c; id_seen = pulse_id; end
            end
            if (c == 10) req_in = '0;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("[TB] FAIL single_count: got %0d required 1", pulses); end
        checks++;
        if (first != 2) begin errors++; $display("[TB] FAIL single_latency: got %0d required 2", first); end
        checks++;
        if (id_seen !== ID_W'(2)) begin errors++; $display("[TB] FAIL single_id: got %0d required 2", id_seen); end
    endtask

    task automatic test_simultaneous();
        int ids[$];
        logic [N_REQ-1:0] pends[$];
        int lows[$];
        int low = 0;
        logic [N_REQ-1:0] e;
        do_reset();
        enable = 1'b1;
        req_in = '1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL simul_model cyc %0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            if (pulse_out) begin
                if (ids.size() > 0) lows.push_back(low);
                ids.push_back(int'(pulse_id));
                pends.push_back(pending);
                low = 0;
            end else if (ids.size() > 0) begin
                low++;
            end
        end
        checks++;
        if (ids.size() != N_REQ) begin
            errors++; $display("[TB] FAIL simul_count: got %0d required %0d", ids.size(), N_REQ);
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                e = '1;
                e = e << (i + 1);
                checks++;
                if (ids[i] != i) begin errors++; $display("[TB] FAIL simul_id %0d: got %0d required %0d", i, ids[i], i); end
                checks++;
                if (pends[i] !== e) begin errors++; $display("[TB] FAIL simul_pending %0d: got %b required %b", i, pends[i], e); end
            end
            for (int i = 0; i < N_REQ - 1; i++) begin
                checks++;
                if (lows[i] != GAP_CYCLES + 1) begin
                    errors++; $display("[TB] FAIL simul_spacing %0d: got %0d required %0d", i, lows[i], GAP_CYCLES + 1);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int ids[$];
        bit seen = 0;
        do_reset();
        enable = 1'b1;
        req_in = 4'b0010;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLK);
            if (pulse_out) seen = 1;
        end
        checks++;
        if (!seen || pulse_id !== ID_W'(1)) begin
            errors++; $display("[TB] FAIL wrap_first: seen %0d id %0d required id 1", seen, pulse_id);
        end
        req_in = '0;
        @(negedge CLK);
        req_in = 4'b0011;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL wrap_model cyc %0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            if (pulse_out) ids.push_back(int'(pulse_id));
        end
        checks++;
        if (ids.size() != 2) begin
            errors++; $display("[TB] FAIL wrap_count: got %0d required 2", ids.size());
        end else begin
            checks++;
            if (ids[0] != 0 || ids[1] != 1) begin
                errors++; $display("[TB] FAIL wrap_order: got %0d,%0d required 0,1", ids[0], ids[1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [N_REQ-1:0] seq [3] = '{4'b0010, 4'b0000, 4'b0010};
        int id1 = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_in = seq[i];
            @(negedge CLK);
        end
        checks++;
        if (overflow !== 1'b1 || pending !== 4'b0010) begin
            errors++; $display("[TB] FAIL ovf_set: overflow %b pending %b required 1 0010", overflow, pending);
        end
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL ovf_model cyc %0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            if (pulse_out && pulse_id == ID_W'(1)) id1++;
        end
        checks++;
        if (id1 != 1 || overflow !== 1'b1) begin
            errors++; $display("[TB] FAIL ovf_single_grant: pulses %0d overflow %b required 1 1", id1, overflow);
        end
        clr_ovf = 1'b1;
        @(negedge CLK);
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b required 0", overflow); end
        enable = 1'b0;
        req_in = '0;
        @(negedge CLK);
        req_in = 4'b0010;
        @(negedge CLK);
        req_in = '0;
        @(negedge CLK);
        req_in = 4'b0010; clr_ovf = 1'b1;
        @(negedge CLK);
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_loss_beats_clear: got %b required 1", overflow); end
    endtask

    task automatic test_enable_reset();
        int pulses = 0;
        do_reset();
        req_in = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (pulse_out) pulses++;
        end
        checks++;
        if (pulses != 0 || pending !== 4'b0100) begin
            errors++; $display("[TB] FAIL enable_hold: pulses %0d pending %b required 0 0100", pulses, pending);
        end
        enable = 1'b1;
        @(negedge CLK);
        checks++;
        if (pulse_out !== 1'b1 || pulse_id !== ID_W'(2)) begin
            errors++; $display("[TB] FAIL enable_release: pulse %b id %0d required 1 2", pulse_out, pulse_id);
        end
        req_in = 4'b1100;
        @(negedge CLK);
        checks++;
        if (obs_vec() !== exp_vec() || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL gap_state: got %b required %b", obs_vec(), exp_vec());
        end
        #2 RST = 1'b1; req_in = '0;
        #1;
        checks++;
        if (pulse_out !== 1'b0 || pending !== '0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_gap: got %b required all zero", obs_vec());
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random_model cyc %0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            RST     = ($urandom_range(0, 199) == 0);
            req_in  = req_in ^ (N_REQ'($urandom) & N_REQ'($urandom) & N_REQ'($urandom));
            enable  = ($urandom_range(0, 9) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
        end
        RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_wrap();
        test_overflow();
        test_enable_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
